// File: rtl/muldiv_seq.sv
// muldiv_seq - multi-cycle multiply/divide sequencer for the HI/LO unit.
//
// It has no adder of its own. It borrows the shared ALU through alu_src1_o,
// alu_src2_o and alu_ctrl_o. The ALU result comes back combinationally on
// alu_result_i in the same cycle.
//
// Ports:
//   clk_i, rst_i       clock; asynchronous active-high reset
//   start_i, op_i      request; op 00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   src1_i, src2_i     multiplicand/dividend, multiplier/divisor
//   flush_i            abort any in-flight operation
//   busy_o, done_o     busy outside IDLE; one-cycle completion pulse
//   div_zero_o         divide-by-zero flag, valid with done_o
//   hi_o, lo_o         product[2W-1:W]/remainder, product[W-1:0]/quotient
//   alu_*              shared ALU operand/control port and its result
//
// Build option: MULDIV_DIV_EN. When it is defined, DIVU/DIV are implemented.
// When it is undefined, divide requests complete early with zero results.
module muldiv_seq #(
    parameter int WIDTH            = 32,
    parameter int ALUCONTROL_WIDTH = 4
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        start_i,
    input  logic [1:0]                  op_i,
    input  logic [WIDTH-1:0]            src1_i,
    input  logic [WIDTH-1:0]            src2_i,
    input  logic                        flush_i,
    output logic                        busy_o,
    output logic                        done_o,
    output logic                        div_zero_o,
    output logic [WIDTH-1:0]            hi_o,
    output logic [WIDTH-1:0]            lo_o,
    output logic [WIDTH-1:0]            alu_src1_o,
    output logic [WIDTH-1:0]            alu_src2_o,
    output logic [ALUCONTROL_WIDTH-1:0] alu_ctrl_o,
    input  logic [WIDTH-1:0]            alu_result_i
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);
    localparam logic [ALUCONTROL_WIDTH-1:0] ALU_ADD = ALUCONTROL_WIDTH'(4'b0010);
    localparam logic [ALUCONTROL_WIDTH-1:0] ALU_SUB = ALUCONTROL_WIDTH'(4'b0110);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PREP = 3'd1;
    localparam logic [2:0] S_ITER = 3'd2;
    localparam logic [2:0] S_FIX  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [1:0]       op_q, op_d;
    // h: multiply accumulator or remainder.
    // l: multiplier or dividend/quotient.
    // m: multiplicand or divisor.
    // Before PREP, l holds raw src1 and m holds raw src2.
    logic [WIDTH-1:0] h_q, h_d, l_q, l_d, m_q, m_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             sign_q, sign_d;
    logic             dz_q, dz_d;
`ifdef MULDIV_DIV_EN
    logic             sign_r_q, sign_r_d;
`endif

    // Absolute values for PREP. Negation is done locally because the ALU
    // port is reserved for iterations.
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] abs_a, abs_b;
    assign a_neg = op_q[0] & l_q[WIDTH-1];
    assign b_neg = op_q[0] & m_q[WIDTH-1];
    assign abs_a = a_neg ? -l_q : l_q;
    assign abs_b = b_neg ? -m_q : m_q;

    // Multiply step. The carry out of H+M is recovered from the unsigned
    // wrap of the ALU sum.
    logic             mul_carry;
    logic [WIDTH-1:0] mul_s;
    assign mul_carry = l_q[0] & (alu_result_i < h_q);
    assign mul_s     = l_q[0] ? alu_result_i : h_q;

    logic [2*WIDTH-1:0] prod_fix;
    assign prod_fix = sign_q ? -{h_q, l_q} : {h_q, l_q};

`ifdef MULDIV_DIV_EN
    // Restoring divide step on {R,Q} shifted left by one.
    logic             div_msb, div_ge;
    logic [WIDTH-1:0] div_r, div_qs;
    assign div_msb = h_q[WIDTH-1];
    assign div_r   = {h_q[WIDTH-2:0], l_q[WIDTH-1]};
    assign div_qs  = {l_q[WIDTH-2:0], 1'b0};
    assign div_ge  = div_msb | (div_r >= m_q);
`endif

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        h_d        = h_q;
        l_d        = l_q;
        m_d        = m_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        cnt_d      = cnt_q;
        sign_d     = sign_q;
        dz_d       = dz_q;
`ifdef MULDIV_DIV_EN
        sign_r_d   = sign_r_q;
`endif
        alu_src1_o = '0;
        alu_src2_o = '0;
        alu_ctrl_o = ALU_ADD;

        case (state_q)
            S_IDLE: begin
                if (start_i && !flush_i) begin
                    state_d = S_PREP;
                    op_d    = op_i;
                    l_d     = src1_i;
                    m_d     = src2_i;
                end
            end
            S_PREP: begin
                sign_d = a_neg ^ b_neg;
`ifdef MULDIV_DIV_EN
                sign_r_d = a_neg;
`endif
                cnt_d  = '0;
                h_d    = '0;
                dz_d   = 1'b0;
                if (op_q[1]) begin
`ifdef MULDIV_DIV_EN
                    if (m_q == '0) begin
                        hi_d    = l_q;
                        lo_d    = '1;
                        dz_d    = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        l_d     = abs_a;
                        m_d     = abs_b;
                        state_d = S_ITER;
                    end
`else
                    hi_d    = '0;
                    lo_d    = '0;
                    state_d = S_DONE;
`endif
                end else begin
                    l_d     = abs_b;
                    m_d     = abs_a;
                    state_d = S_ITER;
                end
            end
            S_ITER: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST_ITER) state_d = S_FIX;
`ifdef MULDIV_DIV_EN
                if (op_q[1]) begin
                    alu_src1_o = div_r;
                    alu_src2_o = m_q;
                    alu_ctrl_o = ALU_SUB;
                    if (div_ge) begin
                        h_d = alu_result_i;
                        l_d = div_qs | WIDTH'(1);
                    end else begin
                        h_d = div_r;
                        l_d = div_qs;
                    end
                end else
`endif
                begin
                    alu_src1_o = h_q;
                    alu_src2_o = m_q;
                    alu_ctrl_o = ALU_ADD;
                    h_d = {mul_carry, mul_s[WIDTH-1:1]};
                    l_d = {mul_s[0], l_q[WIDTH-1:1]};
                end
            end
            S_FIX: begin
                state_d = S_DONE;
`ifdef MULDIV_DIV_EN
                if (op_q[1]) begin
                    lo_d = sign_q   ? -l_q : l_q;
                    hi_d = sign_r_q ? -h_q : h_q;
                end else
`endif
                begin
                    {hi_d, lo_d} = prod_fix;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // A flush abandons the operation and leaves the visible results intact.
        if (flush_i && state_q != S_IDLE) begin
            state_d = S_IDLE;
            hi_d    = hi_q;
            lo_d    = lo_q;
            dz_d    = dz_q;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            h_q      <= '0;
            l_q      <= '0;
            m_q      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            cnt_q    <= '0;
            sign_q   <= 1'b0;
            dz_q     <= 1'b0;
`ifdef MULDIV_DIV_EN
            sign_r_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            h_q      <= h_d;
            l_q      <= l_d;
            m_q      <= m_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            cnt_q    <= cnt_d;
            sign_q   <= sign_d;
            dz_q     <= dz_d;
`ifdef MULDIV_DIV_EN
            sign_r_q <= sign_r_d;
`endif
        end
    end

    assign busy_o     = (state_q != S_IDLE);
    assign done_o     = (state_q == S_DONE);
    assign div_zero_o = done_o & dz_q;
    assign hi_o       = hi_q;
    assign lo_o       = lo_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed self-checking bench for muldiv_seq with a behavioural shared ALU.
// Cycle k means the interval after the k-th rising edge counted from the
// edge that samples start_i. Outputs are sampled 1 time unit after an edge.
module tb_muldiv_seq;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [1:0]    op = 2'b00;
    logic [W-1:0]  s1 = '0, s2 = '0;
    logic          flush = 1'b0;
    logic          busy, done, dz;
    logic [W-1:0]  hi, lo, a1, a2, ares;
    logic [3:0]    actrl;

    int n_cmp = 0;
    int n_err = 0;

    muldiv_seq #(.WIDTH(W), .ALUCONTROL_WIDTH(4)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .op_i(op),
        .src1_i(s1), .src2_i(s2), .flush_i(flush),
        .busy_o(busy), .done_o(done), .div_zero_o(dz),
        .hi_o(hi), .lo_o(lo),
        .alu_src1_o(a1), .alu_src2_o(a2), .alu_ctrl_o(actrl),
        .alu_result_i(ares)
    );

    // Shared ALU model: add / subtract only.
    assign ares = (actrl == 4'b0010) ? a1 + a2 :
                  (actrl == 4'b0110) ? a1 - a2 : '0;

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issues one operation, finds done_o within a bounded wait, and then
    // checks the latency, the results, ITER ALU control and the return to IDLE.
    task automatic run_op(input string tag, input logic [1:0] o,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input int exp_cyc, input logic [W-1:0] exp_hi,
                          input logic [W-1:0] exp_lo, input logic exp_dz,
                          input logic [3:0] exp_ctrl);
        int cyc;
        int bad_ctrl;
        op = o; s1 = a; s2 = b; start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 1;
        bad_ctrl = 0;
        while (!done && cyc < 60) begin
            if (cyc >= 2 && cyc <= W + 1 && actrl !== exp_ctrl) bad_ctrl++;
            tick();
            cyc++;
        end
        chk({tag, " done_cycle"}, W'(cyc), W'(exp_cyc));
        chk({tag, " hi"}, hi, exp_hi);
        chk({tag, " lo"}, lo, exp_lo);
        chk({tag, " div_zero"}, W'(dz), W'(exp_dz));
        chk({tag, " busy_at_done"}, W'(busy), W'(1));
        chk({tag, " iter_ctrl_bad"}, W'(bad_ctrl), W'(0));
        tick();
        chk({tag, " idle_after"}, W'({busy, done}), W'(0));
    endtask

    initial begin
        int ndone;
        // Reset state
        rst = 1'b1;
        #12;
        chk("rst busy", W'(busy), W'(0));
        chk("rst done", W'(done), W'(0));
        chk("rst dz", W'(dz), W'(0));
        chk("rst hi", hi, '0);
        chk("rst lo", lo, '0);
        chk("rst alu1", a1, '0);
        chk("rst alu2", a2, '0);
        chk("rst ctrl", W'(actrl), W'(4'b0010));
        rst = 1'b0;
        tick();

        run_op("multu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 35,
               32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 4'b0010);
        run_op("mult_neg", 2'b01, 32'hFFFF_FFFD, 32'd7, 35,
               32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 4'b0010);

        // Flush mid-ITER: hi/lo keep the previous MULT result.
        op = 2'b00; s1 = 32'd3; s2 = 32'd4; start = 1'b1;
        tick();
        start = 1'b0;
        ndone = 0;
        chk("flush prep alu1", a1, '0);
        for (int c = 2; c <= 10; c++) begin
            tick();
            if (done) ndone++;
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush busy", W'(busy), W'(0));
        for (int c = 12; c <= 20; c++) begin
            tick();
            if (done) ndone++;
        end
        chk("flush no_done", W'(ndone), W'(0));
        chk("flush hi", hi, 32'hFFFF_FFFF);
        chk("flush lo", lo, 32'hFFFF_FFEB);
        run_op("after_flush", 2'b00, 32'd3, 32'd4, 35, 32'd0, 32'd12, 1'b0, 4'b0010);

        // Flush together with start in IDLE drops the request.
        start = 1'b1; flush = 1'b1;
        tick();
        start = 1'b0; flush = 1'b0;
        chk("flush_start busy", W'(busy), W'(0));

`ifdef MULDIV_DIV_EN
        run_op("div_neg", 2'b11, 32'hFFFF_FFF9, 32'd2, 35,
               32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 4'b0110);
        run_op("divu", 2'b10, 32'd100, 32'd7, 35, 32'd2, 32'd14, 1'b0, 4'b0110);
        run_op("divu_zero", 2'b10, 32'd5, 32'd0, 2, 32'd5, 32'hFFFF_FFFF, 1'b1, 4'b0110);
        run_op("div_ovf", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 35,
               32'd0, 32'h8000_0000, 1'b0, 4'b0110);
`else
        run_op("div_neg", 2'b11, 32'hFFFF_FFF9, 32'd2, 2, 32'd0, 32'd0, 1'b0, 4'b0010);
        run_op("divu", 2'b10, 32'd100, 32'd7, 2, 32'd0, 32'd0, 1'b0, 4'b0010);
        run_op("divu_zero", 2'b10, 32'd5, 32'd0, 2, 32'd0, 32'd0, 1'b0, 4'b0010);
`endif

        // Asynchronous reset mid-ITER, between clock edges.
        run_op("pre_rst", 2'b00, 32'd5, 32'd6, 35, 32'd0, 32'd30, 1'b0, 4'b0010);
        op = 2'b00; s1 = 32'd9; s2 = 32'd9; start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 2; c <= 15; c++) tick();
        #2 rst = 1'b1;
        #1;
        chk("arst busy", W'(busy), W'(0));
        chk("arst hi", hi, '0);
        chk("arst lo", lo, '0);
        #1 rst = 1'b0;
        tick();

        // start_i while busy is ignored: exactly one completion is expected.
        op = 2'b00; s1 = 32'd2; s2 = 32'd3; start = 1'b1;
        tick();
        start = 1'b0;
        ndone = 0;
        for (int c = 2; c <= 50; c++) begin
            if (c == 5) begin
                op = 2'b00; s1 = 32'd7; s2 = 32'd7; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            tick();
            if (done) ndone++;
        end
        chk("busy_start ndone", W'(ndone), W'(1));
        chk("busy_start lo", lo, 32'd6);
        chk("busy_start hi", hi, 32'd0);
        chk("busy_start idle", W'(busy), W'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Global time bound so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: observed no finish, required finish");
        $fatal(1, "timeout");
    end

endmodule
